counter_sequencer: RTL

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/counter_sequencer.sv
// Two-requester command sequencer driving a loadable up/down counter.
// Round-robin grants one command at a time, runs it for len+1 cycles, then pulses done.
module counter_sequencer #(
  parameter int unsigned W  = 4,
  parameter int unsigned LW = 4
) (
  input  logic          clk,
  input  logic          res,
  input  logic          req0_valid,
  input  logic [1:0]    req0_op,
  input  logic [LW-1:0] req0_len,
  input  logic [W-1:0]  req0_data,
  input  logic          req1_valid,
  input  logic [1:0]    req1_op,
  input  logic [LW-1:0] req1_len,
  input  logic [W-1:0]  req1_data,
  output logic          req0_ready,
  output logic          req1_ready,
  output logic          s0,
  output logic          s1,
  output logic [W-1:0]  x,
  output logic [W-1:0]  cnt_q,
  output logic          busy,
  output logic          done,
  output logic          owner
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_HOLD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic [1:0]    op;
    logic [LW-1:0] len;
    logic [W-1:0]  data;
  } cmd_t;

  state_e        state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  cnt_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          owner_q, owner_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          grant0_c, grant1_c;
  cmd_t          cmd_c;

  // Round-robin arbitration; a tie goes to the requester that was not granted last.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (res && (state_q == ST_IDLE)) begin
      if (req0_valid && req1_valid) begin
        grant0_c = owner_q;
        grant1_c = ~owner_q;
      end else begin
        grant0_c = req0_valid;
        grant1_c = req1_valid;
      end
    end
  end

  always_comb begin
    cmd_c.op   = grant1_c ? req1_op   : req0_op;
    cmd_c.len  = grant1_c ? req1_len  : req0_len;
    cmd_c.data = grant1_c ? req1_data : req0_data;
  end

  // Next-state and next-output logic; the mode/x registers hold the latched command.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    owner_d = owner_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant0_c || grant1_c) begin
          mode_d  = cmd_c.op;
          x_d     = cmd_c.data;
          rem_d   = (cmd_c.op == OP_LOAD) ? '0 : cmd_c.len;
          owner_d = grant1_c;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        unique case (mode_q)
          OP_LOAD: cnt_d = x_q;
          OP_UP:   cnt_d = cnt_q + W'(1);
          OP_DOWN: cnt_d = cnt_q - W'(1);
          OP_HOLD: cnt_d = cnt_q;
          default: cnt_d = cnt_q;
        endcase
        if (rem_q == '0) begin
          mode_d  = OP_HOLD;
          x_d     = '0;
          state_d = ST_DONE;
        end else begin
          rem_d = rem_q - LW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        mode_d  = OP_HOLD;
        x_d     = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q <= ST_IDLE;
      mode_q  <= OP_HOLD;
      x_q     <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      owner_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      owner_q <= owner_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign req0_ready = grant0_c;
  assign req1_ready = grant1_c;
  assign s0         = mode_q[1];
  assign s1         = mode_q[0];
  assign x          = x_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign owner      = owner_q;

endmodule
